pwm_fade_controller: RTL and testbench

- Sequencer that drives the `duty`, `step` and `ena` inputs of one `pwm` instance (duty width N) to produce linear fade-in / hold / fade-out ("breathing") envelopes.
- Contains a programmable prescaler that generates the PWM `step` strobe.
- Contains a start/stop handshake and a one-shot or looping envelope FSM.
- Sits between register/button logic and the `pwm` datapath.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_fade_controller_tick_gen.sv | 30 +++
 rtl/pwm_fade_controller.sv | 170 +++++++++++++++++
 tb/tb_pwm_fade_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the PWM fade sequencer and its helpers.
// No logic; pure declarations.
// No flow control.
package pwm_pkg;

  // Default duty width, prescaler/ramp divider width and hold-time width.
  localparam int PWM_N_DEF      = 8;
  localparam int PRESCALE_W_DEF = 16;
  localparam int HOLD_W_DEF     = 8;

  // Envelope sequencer states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } fade_state_t;

endpackage

// File: rtl/pwm_fade_controller_tick_gen.sv
// Free-running prescaler: one-cycle tick every period+1 clk cycles.
// Tick is combinational from the counter, same cycle the counter hits period.
// No backpressure; period is live and may change at any time.
module tick_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt;

  // Tick is suppressed during reset so the strobe reads 0 while rst is held.
  assign tick = ~rst & (cnt == period);

  // Count up and return to 0 on a match; if period drops below cnt, the
  // counter simply wraps through 2^W before it can match again.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == period) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_fade_controller.sv
// Breathing-envelope sequencer driving duty/step/ena of one pwm instance.
// duty is registered (one edge after an update event); done is a same-cycle pulse.
// No backpressure; start is accepted only in IDLE, stop only while busy.
module pwm_fade_controller
  import pwm_pkg::*;
#(
  parameter int N          = PWM_N_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int HOLD_W     = HOLD_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] ramp_div,
  input  logic [N-1:0]          peak,
  input  logic [HOLD_W-1:0]     hold,
  output logic                  pwm_step,
  output logic                  pwm_ena,
  output logic [N-1:0]          duty,
  output logic                  busy,
  output logic                  done
);

  fade_state_t           state;
  fade_state_t           state_nxt;
  logic [N-1:0]          duty_nxt;
  logic [PRESCALE_W-1:0] ramp_cnt;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [PRESCALE_W-1:0] ramp_div_q;
  logic [N-1:0]          peak_q;
  logic [HOLD_W-1:0]     hold_q;
  logic                  loop_q;
  logic                  load_cfg;
  logic                  finish;
  logic                  update_ev;
  logic                  hold_ev;
  logic                  loop_live;
  logic                  state_chg;

  tick_gen #(
    .W (PRESCALE_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .period (prescale),
    .tick   (pwm_step)
  );

  assign busy      = (state != IDLE);
  assign pwm_ena   = busy;
  assign update_ev = pwm_step & (ramp_cnt == ramp_div_q);
  assign hold_ev   = pwm_step & (hold_cnt == hold_q);
  // A stop arriving in the same cycle as the end-of-ramp/hold decision
  // already counts, so the envelope ends instead of starting one more pass.
  assign loop_live = loop_q & ~stop;
  assign state_chg = (state_nxt != state);
  // done fires in the last busy cycle, so a start in that same cycle still
  // sees a busy state and is ignored.
  assign done      = finish & ~rst;

  // Next-state and next-duty decision for the envelope.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    load_cfg  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RAMP_UP;
          load_cfg  = 1'b1;
          duty_nxt  = '0;
        end
      end
      RAMP_UP: begin
        if (stop) begin
          // Fade out from wherever the ramp currently is.
          state_nxt = RAMP_DOWN;
        end else if (update_ev) begin
          if (duty == peak_q) begin
            state_nxt = HOLD_HIGH;
          end else begin
            duty_nxt = duty + 1'b1;
          end
        end
      end
      HOLD_HIGH: begin
        if (stop || hold_ev) begin
          state_nxt = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (update_ev) begin
          if (duty == '0) begin
            if (loop_live) begin
              state_nxt = HOLD_LOW;
            end else begin
              state_nxt = IDLE;
              finish    = 1'b1;
            end
          end else begin
            duty_nxt = duty - 1'b1;
          end
        end
      end
      HOLD_LOW: begin
        if (hold_ev) begin
          if (loop_live) begin
            state_nxt = RAMP_UP;
          end else begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        duty_nxt  = '0;
      end
    endcase
  end

  // State and duty registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      duty  <= '0;
    end else begin
      state <= state_nxt;
      duty  <= duty_nxt;
    end
  end

  // Envelope configuration is captured on the start edge; stop while busy
  // drops the loop request so the current pass is the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ramp_div_q <= '0;
      peak_q     <= '0;
      hold_q     <= '0;
      loop_q     <= 1'b0;
    end else if (load_cfg) begin
      ramp_div_q <= ramp_div;
      peak_q     <= peak;
      hold_q     <= hold;
      loop_q     <= loop_en;
    end else if (busy && stop) begin
      loop_q <= 1'b0;
    end
  end

  // Ramp divider and hold counters count pwm_step pulses within a state and
  // restart from 0 whenever the state changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ramp_cnt <= '0;
      hold_cnt <= '0;
    end else if (state_chg) begin
      ramp_cnt <= '0;
      hold_cnt <= '0;
    end else if (pwm_step) begin
      ramp_cnt <= update_ev ? '0 : ramp_cnt + 1'b1;
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Self-checking bench for pwm_fade_controller: directed table, hand-written
// corner sequences and randomized traffic compared against a phase/step model.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_pwm_fade_controller;

  localparam int N  = 8;
  localparam int PW = 16;
  localparam int HW = 8;

  localparam int P_IDLE = 0;
  localparam int P_UP   = 1;
  localparam int P_HH   = 2;
  localparam int P_DN   = 3;
  localparam int P_HL   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [PW-1:0] ramp_div = '0;
  logic [N-1:0]  peak = '0;
  logic [HW-1:0] hold = '0;
  logic          pwm_step;
  logic          pwm_ena;
  logic [N-1:0]  duty;
  logic          busy;
  logic          done;

  pwm_fade_controller #(.N(N), .PRESCALE_W(PW), .HOLD_W(HW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .prescale (prescale),
    .ramp_div (ramp_div),
    .peak     (peak),
    .hold     (hold),
    .pwm_step (pwm_step),
    .pwm_ena  (pwm_ena),
    .duty     (duty),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase of the envelope, steps seen since entering it,
  // clocks since the last step, and the configuration taken at start.
  int m_tc = 0, m_phase = P_IDLE, m_k = 0, m_duty = 0;
  int m_peak = 0, m_hold = 0, m_rdiv = 0, m_loop = 0;

  // Sampled outputs and per-envelope statistics.
  bit s_busy, s_step, s_done;
  int s_duty = 0, prev_duty = 0;
  int n_done = 0, n_busy = 0, max_duty = 0, n_rise = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_step();
    return !rst && (m_tc == int'(prescale));
  endfunction

  function automatic bit m_update();
    return m_step() && (m_phase == P_UP || m_phase == P_DN) &&
           ((m_k % (m_rdiv + 1)) == m_rdiv);
  endfunction

  function automatic bit m_hold_ev();
    return m_step() && (m_phase == P_HH || m_phase == P_HL) && (m_k == m_hold);
  endfunction

  function automatic bit m_done();
    bit last_pass;
    last_pass = !(m_loop != 0 && !stop);
    return !rst && last_pass &&
           ((m_phase == P_DN && m_update() && m_duty == 0) ||
            (m_phase == P_HL && m_hold_ev()));
  endfunction

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_edge();
    int nph, nd;
    bit st, up, he, lp;
    if (rst) begin
      m_tc = 0; m_phase = P_IDLE; m_k = 0; m_duty = 0;
      m_peak = 0; m_hold = 0; m_rdiv = 0; m_loop = 0;
      return;
    end
    st = m_step(); up = m_update(); he = m_hold_ev();
    lp = (m_loop != 0) && !stop;
    nph = m_phase; nd = m_duty;
    case (m_phase)
      P_IDLE: if (start) begin
        nph = P_UP; nd = 0;
        m_peak = int'(peak); m_hold = int'(hold); m_rdiv = int'(ramp_div); m_loop = int'(loop_en);
      end
      P_UP: if (stop) nph = P_DN;
            else if (up) begin
              if (m_duty == m_peak) nph = P_HH; else nd = m_duty + 1;
            end
      P_HH: if (stop || he) nph = P_DN;
      P_DN: if (up) begin
              if (m_duty == 0) nph = lp ? P_HL : P_IDLE; else nd = m_duty - 1;
            end
      P_HL: if (he) nph = lp ? P_UP : P_IDLE;
      default: nph = P_IDLE;
    endcase
    if (m_phase != P_IDLE && stop) m_loop = 0;
    m_k = (nph != m_phase) ? 0 : (st ? m_k + 1 : m_k);
    m_tc = st ? 0 : (m_tc + 1) % 65536;
    m_phase = nph;
    m_duty = nd;
  endtask

  task automatic clear_stats();
    n_done = 0; n_busy = 0; max_duty = 0; n_rise = 0; prev_duty = 0;
  endtask

  // One clock: compare every output against the model, gather stats, step model.
  task automatic cycle();
    @(negedge clk);
    s_duty = int'(duty); s_busy = busy; s_step = pwm_step; s_done = done;
    check("duty", s_duty, m_duty);
    check("busy", int'(s_busy), int'(m_phase != P_IDLE));
    check("pwm_ena", int'(pwm_ena), int'(m_phase != P_IDLE));
    check("pwm_step", int'(s_step), int'(m_step()));
    check("done", int'(s_done), int'(m_done()));
    if (s_done) n_done++;
    if (s_busy) n_busy++;
    if (s_duty > max_duty) max_duty = s_duty;
    if (s_duty == 1 && prev_duty == 0) n_rise++;
    prev_duty = s_duty;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (n < bound) begin
      cycle();
      n++;
      if (!s_busy) break;
    end
    check(name, int'(s_busy), 0);
  endtask

  task automatic set_cfg(input int ps, input int rd, input int pk, input int hd, input bit lp);
    prescale = PW'(ps); ramp_div = PW'(rd); peak = N'(pk); hold = HW'(hd); loop_en = lp;
  endtask

  typedef struct {
    int ps;
    int rd;
    int pk;
    int hd;
    int exp_busy;
    int exp_max;
  } vec_t;

  vec_t tbl[7];
  int   pat[6];
  int   hh_entries, lastph;
  bit   stopped;

  initial begin
    // One-shot envelopes from reset: busy cycles = 2*(peak+1)*(ramp_div+1) + hold + 1
    // when prescale is 0; the prescale=1 row was worked out by hand.
    tbl[0] = '{0, 1,   4, 2,  23,   4};
    tbl[1] = '{0, 0, 255, 0, 513, 255};
    tbl[2] = '{0, 0,   0, 0,   3,   0};
    tbl[3] = '{0, 3,   0, 5,  14,   0};
    tbl[4] = '{0, 0,   1, 1,   6,   1};
    tbl[5] = '{0, 2,   5, 0,  37,   5};
    tbl[6] = '{1, 0,   2, 1,  15,   2};
    pat = '{0, 0, 1, 0, 0, 1};

    // Reset state and prescaler cadence with prescale=2.
    prescale = 16'd2;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rst_step_pattern", int'(s_step), pat[i]);
      check("rst_idle_busy", int'(s_busy), 0);
      check("rst_idle_duty", s_duty, 0);
    end

    // Directed one-shot envelopes.
    for (int i = 0; i < 7; i++) begin
      set_cfg(tbl[i].ps, tbl[i].rd, tbl[i].pk, tbl[i].hd, 1'b0);
      do_reset();
      clear_stats();
      pulse_start();
      wait_idle("tbl_idle", 3000);
      check("tbl_busy_cycles", n_busy, tbl[i].exp_busy);
      check("tbl_max_duty", max_duty, tbl[i].exp_max);
      check("tbl_done_count", n_done, 1);
      check("tbl_end_duty", s_duty, 0);
    end

    // Stop mid-ramp at duty 57: fade-out starts from 57 without reaching peak.
    set_cfg(0, 0, 200, 4, 1'b0);
    do_reset();
    clear_stats();
    pulse_start();
    for (int c = 0; c < 300 && m_duty != 57; c++) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("stop_ramp_duty_at_stop", s_duty, 57);
    cycle();
    check("stop_ramp_duty_hold", s_duty, 57);
    cycle();
    check("stop_ramp_duty_dec", s_duty, 56);
    wait_idle("stop_ramp_idle", 500);
    check("stop_ramp_max", max_duty, 57);
    check("stop_ramp_done", n_done, 1);

    // Looping envelope stopped during its second HOLD_HIGH.
    set_cfg(0, 0, 3, 3, 1'b1);
    do_reset();
    clear_stats();
    pulse_start();
    hh_entries = 0; lastph = m_phase; stopped = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (m_phase == P_HH && lastph != P_HH) hh_entries++;
      lastph = m_phase;
      stop = (m_phase == P_HH && hh_entries == 2 && !stopped);
      if (stop) stopped = 1'b1;
      cycle();
      if (!s_busy) break;
    end
    stop = 1'b0;
    check("loop_stop_issued", int'(stopped), 1);
    check("loop_ended", int'(s_busy), 0);
    check("loop_ramp_ups", n_rise, 2);
    check("loop_done", n_done, 1);
    check("loop_max", max_duty, 3);

    // Start while busy is ignored, including a different peak and loop_en.
    set_cfg(0, 0, 10, 2, 1'b0);
    do_reset();
    clear_stats();
    pulse_start();
    repeat (3) cycle();
    peak = 8'd50; loop_en = 1'b1; start = 1'b1;
    repeat (3) cycle();
    start = 1'b0; loop_en = 1'b0;
    wait_idle("busy_start_idle", 500);
    check("busy_start_max", max_duty, 10);
    check("busy_start_done", n_done, 1);

    // Stop in IDLE does nothing; start together with stop in IDLE starts.
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("idle_stop_busy", int'(s_busy), 0);
    end
    start = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    cycle();
    check("start_stop_same_cycle", int'(s_busy), 1);
    wait_idle("start_stop_idle", 500);

    // Start coinciding with done is dropped; the next cycle's start is taken.
    set_cfg(0, 0, 2, 0, 1'b0);
    clear_stats();
    pulse_start();
    for (int c = 0; c < 200 && !m_done(); c++) cycle();
    start = 1'b1;
    cycle();
    check("done_start_done", int'(s_done), 1);
    check("done_start_still_busy", int'(s_busy), 1);
    cycle();
    check("done_start_idle", int'(s_busy), 0);
    start = 1'b0;
    cycle();
    check("after_done_start", int'(s_busy), 1);
    wait_idle("after_done_idle", 500);

    // Reset mid-RAMP_UP aborts without done.
    set_cfg(0, 0, 100, 2, 1'b0);
    clear_stats();
    pulse_start();
    repeat (20) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("rst_mid_duty", s_duty, 0);
    check("rst_mid_busy", int'(s_busy), 0);
    repeat (3) cycle();
    check("rst_mid_no_done", n_done, 0);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 10; seg++) begin
      prescale = PW'($urandom_range(0, 3));
      do_reset();
      for (int c = 0; c < 800; c++) begin
        start    = ($urandom_range(0, 7) == 0);
        stop     = ($urandom_range(0, 29) == 0);
        loop_en  = $urandom_range(0, 1) != 0;
        ramp_div = PW'($urandom_range(0, 3));
        peak     = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 255)) : N'($urandom_range(0, 15));
        hold     = HW'($urandom_range(0, 5));
        rst      = ($urandom_range(0, 299) == 0);
        cycle();
      end
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
